// File: rtl/upd7800_clk_pkg.sv
// Shared quarter encoding, hold-point and strobe decode constants for the
// uPD7800 clock-enable generator.
package upd7800_clk_pkg;

  typedef enum logic [1:0] {
    Q_CP1  = 2'd0,
    Q_GAP1 = 2'd1,
    Q_CP2  = 2'd2,
    Q_GAP2 = 2'd3
  } e_quarter;

  // Waits stretch the gap between CP1 falling and CP2 rising.
  localparam e_quarter HOLD_QUARTER = Q_GAP1;

  // Quarter whose first CLK carries each edge strobe.
  localparam e_quarter CP1_POS_Q = Q_CP1;
  localparam e_quarter CP1_NEG_Q = Q_GAP1;
  localparam e_quarter CP2_POS_Q = Q_CP2;
  localparam e_quarter CP2_NEG_Q = Q_GAP2;

  function automatic e_quarter next_quarter(input e_quarter q);
    next_quarter = Q_CP1;
    case (q)
      Q_CP1:   next_quarter = Q_GAP1;
      Q_GAP1:  next_quarter = Q_CP2;
      Q_CP2:   next_quarter = Q_GAP2;
      default: next_quarter = Q_CP1;
    endcase
  endfunction

endpackage

// File: rtl/upd7800_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second CLK edge after RESETB rises.
module upd7800_rst_sync (
  input  logic CLK,
  input  logic RESETB,
  output logic RESETB_SYNC
);

  logic meta;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      meta        <= 1'b0;
      RESETB_SYNC <= 1'b0;
    end else begin
      meta        <= 1'b1;
      RESETB_SYNC <= meta;
    end
  end

endmodule

// File: rtl/upd7800_clkgen.sv
// Two-phase clock-enable generator and reset stretcher for the uPD7800 core.
// Optional WAITB hold at the CP1-fall/CP2-rise gap: define UPD7800_CLKGEN_WAIT_EN.
module upd7800_clkgen
  import upd7800_clk_pkg::*;
#(
  parameter int DIV          = 1,
  parameter int RESET_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic WAITB,
  output logic CP1,
  output logic CP2,
  output logic CP1_POSEDGE,
  output logic CP1_NEGEDGE,
  output logic CP2_POSEDGE,
  output logic CP2_NEGEDGE,
  output logic CPU_RESETB,
  output logic WAITING
);

  localparam int SUB_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DIV - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(RESET_CYCLES);

  logic             run;
  e_quarter         q, q_nxt;
  logic [SUB_W-1:0] sub, sub_nxt;
  logic [RC_W-1:0]  rc, rc_nxt;
  logic             rstb_nxt;
  logic             hold;
  logic             adv;
  logic             strobe;

  upd7800_rst_sync u_rst_sync (
    .CLK         (CLK),
    .RESETB      (RESETB),
    .RESETB_SYNC (run)
  );

`ifndef UPD7800_CLKGEN_WAIT_EN
  logic unused_waitb;
  assign unused_waitb = WAITB;
`endif

  always_comb begin
    hold     = 1'b0;
    q_nxt    = q;
    sub_nxt  = sub;
    rc_nxt   = rc;
    rstb_nxt = CPU_RESETB;
`ifdef UPD7800_CLKGEN_WAIT_EN
    hold = run && (q == HOLD_QUARTER) && (sub == SUB_LAST) && !WAITB;
`endif
    adv = run && !hold;
    if (adv) begin
      if (sub == SUB_LAST) begin
        sub_nxt = '0;
        q_nxt   = next_quarter(q);
        // The first Q3->Q0 step starts cycle 1, so the count reaches
        // RESET_CYCLES one entry before the stretch is complete.
        if (q == Q_GAP2) begin
          if (rc == RC_MAX) rstb_nxt = 1'b1;
          else              rc_nxt   = rc + 1'b1;
        end
      end else begin
        sub_nxt = sub + 1'b1;
      end
    end
    // Strobes fire only on a real step into a quarter's first CLK, never
    // while idling before run or while held.
    strobe = adv && (sub_nxt == '0);
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      q           <= Q_GAP2;
      sub         <= SUB_LAST;
      rc          <= '0;
      CP1         <= 1'b0;
      CP2         <= 1'b0;
      CP1_POSEDGE <= 1'b0;
      CP1_NEGEDGE <= 1'b0;
      CP2_POSEDGE <= 1'b0;
      CP2_NEGEDGE <= 1'b0;
      CPU_RESETB  <= 1'b0;
      WAITING     <= 1'b0;
    end else begin
      q           <= q_nxt;
      sub         <= sub_nxt;
      rc          <= rc_nxt;
      CP1         <= (q_nxt == Q_CP1);
      CP2         <= (q_nxt == Q_CP2);
      CP1_POSEDGE <= strobe && (q_nxt == CP1_POS_Q);
      CP1_NEGEDGE <= strobe && (q_nxt == CP1_NEG_Q);
      CP2_POSEDGE <= strobe && (q_nxt == CP2_POS_Q);
      CP2_NEGEDGE <= strobe && (q_nxt == CP2_NEG_Q);
      CPU_RESETB  <= rstb_nxt;
      WAITING     <= hold;
    end
  end

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Bench for upd7800_clkgen: a DIV=1 and a DIV=3 instance on a shared clock,
// checked every CLK against a position-count model of the machine cycle.
`timescale 1ns/1ps
module tb_upd7800_clkgen;

  localparam int DIV_A = 1;
  localparam int RC_A  = 4;
  localparam int DIV_B = 3;
  localparam int RC_B  = 2;
`ifdef UPD7800_CLKGEN_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // clock / reset
  logic CLK    = 1'b0;
  logic RESETB = 1'b0;
  logic WAITB  = 1'b1;
  always #5 CLK = ~CLK;

  logic a_cp1, a_cp2, a_p1p, a_p1n, a_p2p, a_p2n, a_rstb, a_wait;
  logic b_cp1, b_cp2, b_p1p, b_p1n, b_p2p, b_p2n, b_rstb, b_wait;

  upd7800_clkgen #(.DIV(DIV_A), .RESET_CYCLES(RC_A)) dut_a (
    .CLK(CLK), .RESETB(RESETB), .WAITB(WAITB),
    .CP1(a_cp1), .CP2(a_cp2),
    .CP1_POSEDGE(a_p1p), .CP1_NEGEDGE(a_p1n),
    .CP2_POSEDGE(a_p2p), .CP2_NEGEDGE(a_p2n),
    .CPU_RESETB(a_rstb), .WAITING(a_wait)
  );

  upd7800_clkgen #(.DIV(DIV_B), .RESET_CYCLES(RC_B)) dut_b (
    .CLK(CLK), .RESETB(RESETB), .WAITB(WAITB),
    .CP1(b_cp1), .CP2(b_cp2),
    .CP1_POSEDGE(b_p1p), .CP1_NEGEDGE(b_p1n),
    .CP2_POSEDGE(b_p2p), .CP2_NEGEDGE(b_p2n),
    .CPU_RESETB(b_rstb), .WAITING(b_wait)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: k = number of CLKs the machine cycle has advanced since
  // release (k=1 is the first CLK of CP1). Everything follows from k.
  int rel_edges;
  int k_a, k_b;
  bit adv_a, adv_b, wt_a, wt_b;

  function automatic bit at_hold(input int k, input int div);
    return (k >= 1) && (((k - 1) % (4 * div)) == 2 * div - 1);
  endfunction

  function automatic int quarter_of(input int k, input int div);
    return ((k - 1) % (4 * div)) / div;
  endfunction

  function automatic logic [7:0] expect_outs(input int k, input bit adv,
                                             input bit wt, input int div,
                                             input int rc);
    int pos, qq, ss;
    logic [7:0] v;
    v = '0;
    if (k >= 1) begin
      pos  = (k - 1) % (4 * div);
      qq   = pos / div;
      ss   = pos % div;
      v[7] = (qq == 0);
      v[6] = (qq == 2);
      v[5] = adv && (ss == 0) && (qq == 0);
      v[4] = adv && (ss == 0) && (qq == 1);
      v[3] = adv && (ss == 0) && (qq == 2);
      v[2] = adv && (ss == 0) && (qq == 3);
      v[1] = ((k - 1) / (4 * div)) >= rc;
    end
    v[0] = wt;
    return v;
  endfunction

  task automatic model_step(inout int k, output bit adv, output bit wt,
                            input int div);
    adv = 1'b0;
    wt  = 1'b0;
    if (rel_edges >= 3) begin
      wt  = WAIT_EN && at_hold(k, div) && !WAITB;
      adv = !wt;
      if (adv) k++;
    end
  endtask

  always @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rel_edges = 0;
      k_a = 0; k_b = 0;
      adv_a = 1'b0; adv_b = 1'b0;
      wt_a = 1'b0; wt_b = 1'b0;
    end else begin
      rel_edges++;
      model_step(k_a, adv_a, wt_a, DIV_A);
      model_step(k_b, adv_b, wt_b, DIV_B);
    end
  end

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  int first_p1_edge;
  int p2n_in_rst_a, p2n_in_rst_b;
  logic prev_rstb_a, prev_rstb_b;

  task automatic clear_trackers();
    first_p1_edge = -1;
    p2n_in_rst_a  = 0;
    p2n_in_rst_b  = 0;
    prev_rstb_a   = 1'b0;
    prev_rstb_b   = 1'b0;
  endtask

  task automatic check_outs();
    chk("outs_a", {24'd0, a_cp1, a_cp2, a_p1p, a_p1n, a_p2p, a_p2n, a_rstb, a_wait},
        {24'd0, expect_outs(k_a, adv_a, wt_a, DIV_A, RC_A)});
    chk("outs_b", {24'd0, b_cp1, b_cp2, b_p1p, b_p1n, b_p2p, b_p2n, b_rstb, b_wait},
        {24'd0, expect_outs(k_b, adv_b, wt_b, DIV_B, RC_B)});
    if (RESETB) begin
      if (a_p1p && first_p1_edge < 0) first_p1_edge = rel_edges;
      if (a_p2n && !a_rstb) p2n_in_rst_a++;
      if (b_p2n && !b_rstb) p2n_in_rst_b++;
      if (a_rstb && !prev_rstb_a) chk("p2n_during_stretch_a", p2n_in_rst_a, RC_A);
      if (b_rstb && !prev_rstb_b) chk("p2n_during_stretch_b", p2n_in_rst_b, RC_B);
    end
    prev_rstb_a = a_rstb;
    prev_rstb_b = b_rstb;
  endtask

  // driver tasks
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_outs();
    end
  endtask

  task automatic wait_quarter_a(input int target, input bit want_hold);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      check_outs();
      if (want_hold) found = at_hold(k_a, DIV_A);
      else           found = (k_a >= 1) && (quarter_of(k_a, DIV_A) == target);
    end
    chk("wait_target_reached", {31'd0, found}, 32'd1);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    clear_trackers();
    RESETB = 1'b1;
  endtask

  initial begin
    int gap;
    bit seen;
    clear_trackers();

    // Reset state: everything low while RESETB is held.
    run_cycles(3);

    // Release: first CP1 strobe at the 3rd edge, stretch completes.
    release_reset();
    run_cycles(40);
    chk("first_cp1_posedge_edge", first_p1_edge, 3);
    chk("cpu_resetb_a_high", {31'd0, a_rstb}, 32'd1);
    chk("cpu_resetb_b_high", {31'd0, b_rstb}, 32'd1);

    // Five low WAITB samples starting at the hold point.
    wait_quarter_a(1, 1'b1);
    WAITB = 1'b0;
    gap = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      check_outs();
      if (i == 5) WAITB = 1'b1;
      if (a_p2p) begin
        gap  = i;
        seen = 1'b1;
      end
    end
    WAITB = 1'b1;
    chk("cp2_posedge_delay", gap, WAIT_EN ? 6 : 1);
    run_cycles(12);

    // Randomised WAITB.
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      check_outs();
      WAITB = ($urandom_range(0, 2) != 0);
    end
    WAITB = 1'b1;

    // Async reset while CP2 is high, then the release sequence again.
    wait_quarter_a(2, 1'b0);
    chk("cp2_high_before_reset", {31'd0, a_cp2}, 32'd1);
    #2 RESETB = 1'b0;
    #1 check_outs();
    chk("async_clear_a", {24'd0, a_cp1, a_cp2, a_p1p, a_p1n, a_p2p, a_p2n, a_rstb, a_wait}, 32'd0);
    run_cycles(2);
    release_reset();
    run_cycles(40);
    chk("first_cp1_posedge_edge_again", first_p1_edge, 3);
    chk("cpu_resetb_a_high_again", {31'd0, a_rstb}, 32'd1);

    // Random async resets at random phases with random WAITB.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'($urandom_range(5, 60)); i++) begin
        @(negedge CLK);
        check_outs();
        WAITB = ($urandom_range(0, 3) != 0);
      end
      #($urandom_range(1, 4)) RESETB = 1'b0;
      #0.5 check_outs();
      run_cycles(int'($urandom_range(1, 3)));
      release_reset();
      run_cycles(50);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
